// File: rtl/otp_pkg.sv
// Shared constants and pad status type for the one-time-pad encryptor/decryptor pair.
package otp_pkg;
   localparam int DATA_W   = 8;
   localparam int IDX_W    = 3;
   localparam int NUM_PADS = 1 << IDX_W;

   localparam logic [IDX_W:0] PADS_MAX = (IDX_W+1)'(NUM_PADS);

   typedef enum logic [1:0] {
      PAD_EMPTY,
      PAD_FRESH,
      PAD_SPENT
   } pad_status_e;
endpackage

// File: rtl/otp_decryptor_if.sv
// Key-load, ciphertext-in, plaintext-out and status bundle of the OTP decryptor.
interface otp_decryptor_if;
   import otp_pkg::*;

   logic              key_load;
   logic [IDX_W-1:0]  key_idx;
   logic [DATA_W-1:0] key_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [IDX_W-1:0]  in_idx;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;
   logic              err_reuse;
   logic              err_unloaded;
   logic [IDX_W:0]    pads_left;

   modport master (
      output key_load, key_idx, key_data, in_valid, in_data, in_idx, out_ready,
      input  in_ready, out_valid, out_data, out_idx, err_reuse, err_unloaded, pads_left
   );

   modport slave (
      input  key_load, key_idx, key_data, in_valid, in_data, in_idx, out_ready,
      output in_ready, out_valid, out_data, out_idx, err_reuse, err_unloaded, pads_left
   );
endinterface

// File: rtl/otp_pad_bank.sv
// Pad register file with loaded/used bitmaps and a count of loaded-but-unused pads.
module otp_pad_bank
   import otp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              mark_en,
   input  logic [IDX_W-1:0]  mark_idx,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_pad,
   output pad_status_e       rd_status,
   output logic [IDX_W:0]    pads_left
);
   logic [NUM_PADS-1:0][DATA_W-1:0] pad_q;
   logic [NUM_PADS-1:0]             loaded_q;
   logic [NUM_PADS-1:0]             used_q;
   logic                            wr_fresh;

   // Reloading a still-fresh pad must not count it twice.
   assign wr_fresh = loaded_q[wr_idx] && !used_q[wr_idx];

   always_ff @(posedge clk) begin
      if (wr_en) pad_q[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         loaded_q  <= '0;
         used_q    <= '0;
         pads_left <= '0;
      end else begin
         if (mark_en) used_q[mark_idx] <= 1'b1;
         if (wr_en) begin
            loaded_q[wr_idx] <= 1'b1;
            used_q[wr_idx]   <= 1'b0;
         end
         if (wr_en) begin
            if (!wr_fresh && pads_left != PADS_MAX) pads_left <= pads_left + 1'b1;
         end else if (mark_en && pads_left != '0) begin
            pads_left <= pads_left - 1'b1;
         end
      end
   end

   assign rd_pad = pad_q[rd_idx];

   always_comb begin
      rd_status = PAD_EMPTY;
      if (loaded_q[rd_idx]) rd_status = used_q[rd_idx] ? PAD_SPENT : PAD_FRESH;
   end
endmodule

// File: rtl/otp_decryptor.sv
// One-time-pad decryptor: XORs each ciphertext byte with its indexed pad, once per load.
module otp_decryptor
   import otp_pkg::*;
(
   input logic              clk,
   input logic              rst,
   otp_decryptor_if.slave   bus
);
   logic [DATA_W-1:0] rd_pad;
   pad_status_e       rd_status;
   logic              accept;
   logic              accept_ok;

   // Key load owns the cycle so a pad is never read while being rewritten.
   assign bus.in_ready = !bus.key_load && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign accept_ok    = accept && (rd_status == PAD_FRESH);

   otp_pad_bank u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (bus.key_load),
      .wr_idx    (bus.key_idx),
      .wr_data   (bus.key_data),
      .mark_en   (accept_ok),
      .mark_idx  (bus.in_idx),
      .rd_idx    (bus.in_idx),
      .rd_pad    (rd_pad),
      .rd_status (rd_status),
      .pads_left (bus.pads_left)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid    <= 1'b0;
         bus.out_data     <= '0;
         bus.out_idx      <= '0;
         bus.err_reuse    <= 1'b0;
         bus.err_unloaded <= 1'b0;
      end else begin
         bus.err_reuse    <= accept && (rd_status == PAD_SPENT);
         bus.err_unloaded <= accept && (rd_status == PAD_EMPTY);
         if (accept_ok) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data ^ rd_pad;
            bus.out_idx   <= bus.in_idx;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/otp_decryptor.md
Name: otp_decryptor

Overview:
- Receive-side counterpart of the one-time-pad encryptor.
- Holds a bank of pad (key) bytes, each addressed by a pad index.
- Accepts ciphertext bytes tagged with a pad index and returns plaintext = cipher XOR pad[index].
- Enforces one-time use: each pad decrypts at most one byte per load, and reuse or use of an unloaded pad is flagged and dropped.
- Sits between the cipher-byte source (pins or a UART-side shim) and the plaintext consumer.

Parameters:
DATA_W, 8, width of cipher, plain and pad bytes
IDX_W, 3, pad index width
NUM_PADS, 8, pad count; must equal 2**IDX_W

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
key_load  input  1  write key_data into pad[key_idx] this cycle
key_idx  input  IDX_W  pad index for key_load
key_data  input  DATA_W  pad byte
in_valid  input  1  ciphertext byte offered
in_ready  output  1  block accepts ciphertext this cycle
in_data  input  DATA_W  ciphertext byte
in_idx  input  IDX_W  pad index used by the encryptor
out_valid  output  1  plaintext available
out_ready  input  1  consumer accepts plaintext
out_data  output  DATA_W  plaintext byte
out_idx  output  IDX_W  echo of pad index used
err_reuse  output  1  one-cycle pulse: rejected, pad already used
err_unloaded  output  1  one-cycle pulse: rejected, pad never loaded
pads_left  output  IDX_W+1  count of pads loaded and unused

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_idx=0.
  - err_reuse=0, err_unloaded=0, pads_left=0.
  - loaded[] and used[] bitmaps all 0.
  - Pad contents are don't-care.
- Key load:
  - On key_load: pad[key_idx]<=key_data, loaded[key_idx]<=1, used[key_idx]<=0.
  - pads_left recomputed; reloading an unused pad does not double-count.
- Input handshake: accept when in_valid && in_ready.
  - in_ready = !key_load && (!out_valid || out_ready).
  - Key load always wins the cycle and stalls input.
- State per accept, decided from loaded/used at the accept edge:
  - ACCEPT_OK (loaded=1, used=0):
    - out_data<=in_data^pad[in_idx], out_idx<=in_idx, out_valid<=1.
    - used[in_idx]<=1, pads_left decrements.
  - REJECT_UNLOADED (loaded=0): err_unloaded pulses the following cycle; nothing else changes.
  - REJECT_REUSE (loaded=1, used=1): err_reuse pulses the following cycle; nothing else changes.
  - Rejected bytes are consumed (handshake completes) and never reach the output.
- Latency: plaintext appears exactly 1 cycle after accept. Full throughput of 1 byte/cycle while out_ready=1.
- Output:
  - out_valid holds with stable out_data/out_idx until out_ready.
  - Accept and drain in the same cycle replaces the register, with no bubble.
- Error pulses are exactly one cycle and never overlap out_valid assertion for the same byte.
- pads_left saturates within 0..NUM_PADS.
- Reset mid-transfer drops any held output and clears all bitmaps. The next cycle behaves as post-reset.

Decomposition:
- Shared package otp_pkg holds:
  - DATA_W, IDX_W, NUM_PADS constants.
  - Pad-status enum {PAD_EMPTY, PAD_FRESH, PAD_SPENT}, also used by the encryptor side.
- One sub-module, otp_pad_bank:
  - Pad register file plus loaded/used bitmaps and pads_left counter.
  - Combinational read of pad and status by index; write/mark ports.
- Top-level holds the handshake and output register.

Test Plan:
- Reset, then load pad[3]=0xC3; send in_data=0x5A, in_idx=3 -> next cycle out_valid=1, out_data=0x99, out_idx=3; pads_left 1->0.
- Load all 8 pads with 0x11*(i+1); stream 8 bytes with indices 0..7 back-to-back under out_ready=1 -> 8 consecutive out_valid cycles with correct XOR values; pads_left ends at 0.
- Reuse idx 3 after the first decrypt -> err_reuse pulses 1 cycle, out_valid stays 0, pads_left unchanged. Then reload pad[3] -> the next use of idx 3 succeeds.
- Send idx 5 with no prior load -> err_unloaded pulse, no output.
- Hold out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0, out_data stable. Raising out_ready drains and accepts the next byte in the same cycle.
- Assert key_load together with in_valid -> in_ready=0 and input stalled. Then assert rst while out_valid=1 -> out_valid=0 and pads_left=0 next cycle, and a subsequent use of any index gives err_unloaded.
